mult_fu_ctrl: RTL and testbench

Multiply functional-unit controller for the OOO core. It sits between the multiply reservation station and the CDB, and wraps the 32x32 unsigned pipelined Wallace-tree multiplier.
- Conditions signed operands into magnitudes and drives the multiplier.
- Tracks in-flight ops with a metadata shift pipe aligned to the multiplier's fixed latency.
- Applies sign fix-up and selects the RV32M result half.
- Buffers results in a small FIFO so CDB backpressure never stalls the non-stallable multiplier.

---
 rtl/mult_fu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mult_fu_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu_ctrl.sv
// Multiply functional-unit controller: operand conditioning, latency-matched metadata pipe,
// sign fix-up and result FIFO ahead of the CDB. Optional perf counters via MULT_FU_PERF_EN.
module mult_fu_ctrl #(
  parameter int TAG_W      = 6,
  parameter int MULT_LAT   = 2,
  parameter int RESQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_op,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [TAG_W-1:0] issue_tag,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic [63:0]      mult_prod,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
`ifdef MULT_FU_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      op_cnt
`endif
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  localparam int PTR_W = (RESQ_DEPTH > 1) ? $clog2(RESQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESQ_DEPTH + 1);
  localparam int OCC_W = $clog2(MULT_LAT + RESQ_DEPTH + 1);

  logic fire;
  logic sign_a;
  logic sign_b;
  logic neg;

  // Signed operands are handed to the unsigned multiplier as magnitudes.
  always_comb begin
    fire   = issue_valid & issue_ready;
    sign_a = ((issue_op == OP_MULH) || (issue_op == OP_MULHSU)) & issue_a[31];
    sign_b = (issue_op == OP_MULH) & issue_b[31];
    neg    = sign_a ^ sign_b;
    mult_a = '0;
    mult_b = '0;
    if (fire) begin
      mult_a = sign_a ? (~issue_a + 32'd1) : issue_a;
      mult_b = sign_b ? (~issue_b + 32'd1) : issue_b;
    end
  end

  logic [MULT_LAT-1:0] meta_valid;
  logic [MULT_LAT-1:0] meta_neg;
  logic [TAG_W-1:0]    meta_tag [MULT_LAT];
  logic [1:0]          meta_op  [MULT_LAT];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      meta_valid <= '0;
    end else begin
      meta_valid[0] <= fire;
      for (int i = 1; i < MULT_LAT; i++) begin
        meta_valid[i] <= meta_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    meta_tag[0] <= issue_tag;
    meta_op[0]  <= issue_op;
    meta_neg[0] <= neg;
    for (int i = 1; i < MULT_LAT; i++) begin
      meta_tag[i] <= meta_tag[i-1];
      meta_op[i]  <= meta_op[i-1];
      meta_neg[i] <= meta_neg[i-1];
    end
  end

  logic        exit_valid;
  logic [63:0] prod_fixed;
  logic [31:0] result;

  always_comb begin
    exit_valid = meta_valid[MULT_LAT-1];
    prod_fixed = meta_neg[MULT_LAT-1] ? (~mult_prod + 64'd1) : mult_prod;
    result     = (meta_op[MULT_LAT-1] == OP_MUL) ? prod_fixed[31:0] : prod_fixed[63:32];
  end

  logic [TAG_W-1:0] q_tag  [RESQ_DEPTH];
  logic [31:0]      q_data [RESQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    push = exit_valid & ~flush;
    pop  = cdb_valid & cdb_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_tag[wr_ptr]  <= meta_tag[MULT_LAT-1];
      q_data[wr_ptr] <= result;
    end
  end

  // Head entry drives the CDB; forced quiet while in reset.
  always_comb begin
    cdb_valid = ~rst & (count != '0);
    cdb_tag   = cdb_valid ? q_tag[rd_ptr]  : '0;
    cdb_data  = cdb_valid ? q_data[rd_ptr] : '0;
  end

  logic [OCC_W-1:0] occ;

  // Every op in flight already owns a FIFO slot, so the free-running multiplier never overflows it.
  always_comb begin
    occ = OCC_W'(count);
    for (int i = 0; i < MULT_LAT; i++) begin
      occ = occ + OCC_W'(meta_valid[i]);
    end
    issue_ready = ~rst & ~flush & (occ < OCC_W'(RESQ_DEPTH));
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(RESQ_DEPTH))));

`ifdef MULT_FU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      op_cnt    <= '0;
    end else begin
      if (issue_valid && !issue_ready && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (pop) op_cnt <= op_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_fu_ctrl.sv
// Randomized and directed bench for mult_fu_ctrl against a queue-based reference model
// with a behavioural pipelined multiplier.
module tb_mult_fu_ctrl;

  localparam int TAG_W      = 6;
  localparam int MULT_LAT   = 2;
  localparam int RESQ_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic [31:0]      mult_a;
  logic [31:0]      mult_b;
  logic [63:0]      mult_prod;
  logic             cdb_valid;
  logic             cdb_ready;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
`ifdef MULT_FU_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      op_cnt;
`endif

  mult_fu_ctrl #(.TAG_W(TAG_W), .MULT_LAT(MULT_LAT), .RESQ_DEPTH(RESQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_tag(issue_tag),
    .mult_a(mult_a), .mult_b(mult_b), .mult_prod(mult_prod),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
`ifdef MULT_FU_PERF_EN
    , .stall_cnt(stall_cnt), .op_cnt(op_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Free-running unsigned multiplier with a fixed latency
  logic [63:0] prod_pipe [MULT_LAT];
  always @(posedge clk) begin
    prod_pipe[0] <= {32'b0, mult_a} * {32'b0, mult_b};
    for (int i = 1; i < MULT_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
  end
  assign mult_prod = prod_pipe[MULT_LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               due;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               cyc;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   outstanding = 0;
  logic last_fire;
  logic last_dut_fire;
  int   fire_cyc;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (op)
      2'b01:   p = 64'(sa * sb);
      2'b10:   p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] v);
    longint x = is_signed ? longint'($signed(v)) : longint'({32'b0, v});
    return 32'(x < 0 ? -x : x);
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: sample at negedge+1, score against the model, advance to next negedge
  task automatic tick();
    logic        exp_ready;
    logic        exp_valid;
    logic        pop_m;
    logic [31:0] exp_ma;
    logic [31:0] exp_mb;
    #1;
    exp_ready = !rst && !flush && (outstanding < RESQ_DEPTH);
    exp_valid = !rst && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    vectors++;
    if (issue_ready !== exp_ready) begin
      miscompares++;
      $display("[TB] FAIL issue_ready cyc=%0d got=%b want=%b", cyc, issue_ready, exp_ready);
    end
    vectors++;
    if (cdb_valid !== exp_valid) begin
      miscompares++;
      $display("[TB] FAIL cdb_valid cyc=%0d got=%b want=%b", cyc, cdb_valid, exp_valid);
    end
    if (exp_valid) begin
      vectors++;
      if (cdb_tag !== exp_q[0].tag || cdb_data !== exp_q[0].data) begin
        miscompares++;
        $display("[TB] FAIL cdb_result cyc=%0d got=%h/%h want=%h/%h", cyc, cdb_tag, cdb_data,
                 exp_q[0].tag, exp_q[0].data);
      end
    end
    if (rst) begin
      vectors++;
      if (cdb_tag !== '0 || cdb_data !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cyc=%0d got=%h/%h want=0/0", cyc, cdb_tag, cdb_data);
      end
    end
    last_fire     = issue_valid && exp_ready;
    last_dut_fire = issue_valid && issue_ready;
    exp_ma = '0;
    exp_mb = '0;
    if (last_fire) begin
      exp_ma = magnitude(issue_op == 2'b01 || issue_op == 2'b10, issue_a);
      exp_mb = magnitude(issue_op == 2'b01, issue_b);
      fire_cyc = cyc;
    end
    vectors++;
    if (mult_a !== exp_ma || mult_b !== exp_mb) begin
      miscompares++;
      $display("[TB] FAIL mult_operands cyc=%0d got=%h/%h want=%h/%h", cyc, mult_a, mult_b,
               exp_ma, exp_mb);
    end
    pop_m = exp_valid && cdb_ready;
    if (pop_m && !flush) got_q.push_back('{tag: cdb_tag, data: cdb_data, cyc: cyc});
    if (pop_m) void'(exp_q.pop_front());
    if (rst || flush) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (last_fire)
        exp_q.push_back('{tag: issue_tag, data: ref_result(issue_op, issue_a, issue_b),
                          due: cyc + MULT_LAT + 1});
      outstanding += int'(last_fire) - int'(pop_m);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag);
    issue_valid = v;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_tag   = tag;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    issue_valid = 1'b0;
    cdb_ready   = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout got=%0d left want=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    cdb_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    got_q.delete();
    drive(1'b1, 2'b00, 32'd7, 32'd6, 6'd3);
    tick();
    drain(20);
    vectors++;
    if (got_q.size() != 1 || got_q[0].tag !== 6'd3 || got_q[0].data !== 32'h0000_002A ||
        got_q[0].cyc != fire_cyc + 3) begin
      miscompares++;
      $display("[TB] FAIL basic_mul got=%0d results want=tag 3 data 2a at fire+3", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops  [7] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] as   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] bs   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000, 32'h00000001};
    logic [31:0] want [7] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
                              32'h40000000, 32'h00000000, 32'hFFFFFFFF};
    // Two bursts: first four all-ones ops, then three 0x80000000 corner cases
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 6'(10 + i));
      tick();
    end
    drain(30);
    for (int i = 4; i < 7; i++) begin
      drive(1'b1, ops[i], as[i], bs[i], 6'(10 + i));
      tick();
    end
    drain(30);
    vectors++;
    if (got_q.size() != 7) begin
      miscompares++;
      $display("[TB] FAIL b2b_count got=%0d want=7", got_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (got_q[i].data !== want[i] || got_q[i].tag !== 6'(10 + i)) begin
          miscompares++;
          $display("[TB] FAIL b2b_result[%0d] got=%h/%h want=%h/%h", i, got_q[i].tag,
                   got_q[i].data, 6'(10 + i), want[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (got_q[i].cyc != got_q[0].cyc + i) begin
          miscompares++;
          $display("[TB] FAIL b2b_spacing[%0d] got=%0d want=%0d", i, got_q[i].cyc,
                   got_q[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    int          idx = 0;
    int          dut_acc = 0;
    int          n = 0;
    for (int i = 0; i < 6; i++) begin
      ops[i] = 2'($urandom);
      as[i]  = rand_operand();
      bs[i]  = rand_operand();
    end
    got_q.delete();
    cdb_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, ops[idx], as[idx], bs[idx], 6'(20 + idx));
      tick();
      if (last_dut_fire) dut_acc++;
      if (last_fire && idx < 5) idx++;
    end
    #1;
    vectors++;
    if (dut_acc != 4 || issue_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_accept got=%0d ready=%b want=4 ready=0", dut_acc, issue_ready);
    end
    @(negedge clk);
    cyc++;
    cdb_ready = 1'b1;
    while (idx < 6 && n < 40) begin
      drive(1'b1, ops[idx], as[idx], bs[idx], 6'(20 + idx));
      tick();
      if (last_fire) idx++;
      n++;
    end
    drain(40);
    vectors++;
    if (got_q.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL backpressure_count got=%0d want=6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (got_q[i].tag !== 6'(20 + i)) begin
          miscompares++;
          $display("[TB] FAIL backpressure_order[%0d] got=%0d want=%0d", i, got_q[i].tag, 20 + i);
        end
      end
    end
  endtask

  task automatic test_flush();
    got_q.delete();
    cdb_ready = 1'b0;
    drive(1'b1, 2'b00, $urandom, $urandom, 6'd30);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    tick();
    drive(1'b1, 2'b01, rand_operand(), rand_operand(), 6'd31);
    tick();
    drive(1'b1, 2'b10, rand_operand(), rand_operand(), 6'd32);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cdb_ready = 1'b1;
    repeat (10) tick();
    drive(1'b1, 2'b11, $urandom, $urandom, 6'd33);
    tick();
    drain(20);
    vectors++;
    if (got_q.size() != 1 || got_q[0].tag !== 6'd33 || got_q[0].cyc != fire_cyc + 3) begin
      miscompares++;
      $display("[TB] FAIL flush_recovery got=%0d results want=1 tag 33 at fire+3", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom), rand_operand(), rand_operand(), 6'(40 + i));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cdb_ready = 1'b1;
    repeat (10) tick();
    drive(1'b1, 2'b00, 32'd3, 32'd5, 6'd7);
    tick();
    drain(20);
    vectors++;
    if (got_q.size() != 1 || got_q[0].tag !== 6'd7 || got_q[0].data !== 32'h0000_000F) begin
      miscompares++;
      $display("[TB] FAIL reset_mid got=%0d results want=1 tag 7 data f", got_q.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      flush     = ($urandom_range(0, 99) == 0);
      cdb_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, 2'($urandom), rand_operand(), rand_operand(), 6'($urandom));
      tick();
    end
    flush = 1'b0;
    drain(100);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cdb_ready = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, '0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
